// File: rtl/pq_pkg.sv
// Shared types and helpers for the shift-array priority queue.
// Keys are compared through a fixed-width helper so every key width can share it.
package pq_pkg;

    localparam int PQ_MAX_KW = 64;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_INSERT,
        OP_REMOVE,
        OP_REPLACE
    } pq_op_e;

    typedef enum logic [1:0] {
        SEL_HOLD,
        SEL_LEFT,
        SEL_RIGHT,
        SEL_NEW
    } pq_sel_e;

    function automatic pq_op_e decode_op(input logic enq, input logic deq, input logic repl);
        pq_op_e op;
        op = OP_NOP;
        if (repl || (enq && deq)) begin
            op = OP_REPLACE;
        end else if (enq) begin
            op = OP_INSERT;
        end else if (deq) begin
            op = OP_REMOVE;
        end
        return op;
    endfunction

    // Strict comparison: an equal key is never better, so ties land behind (FIFO).
    function automatic logic better(input logic [PQ_MAX_KW-1:0] a,
                                    input logic [PQ_MAX_KW-1:0] b,
                                    input logic                 min_first);
        return min_first ? (a < b) : (a > b);
    endfunction

endpackage

// File: rtl/pq_cell.sv
// One storage cell of the systolic queue: holds an entry and picks its next
// contents from itself, a neighbour or the broadcast operand.
module pq_cell
    import pq_pkg::*;
#(
    parameter int KW        = 8,
    parameter int VW        = 8,
    parameter int MIN_FIRST = 1,
    parameter bit FIRST     = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  pq_op_e        op,
    input  logic [KW-1:0] new_key,
    input  logic [VW-1:0] new_val,
    input  logic          left_vld,
    input  logic [KW-1:0] left_key,
    input  logic [VW-1:0] left_val,
    input  logic          right_vld,
    input  logic [KW-1:0] right_key,
    input  logic [VW-1:0] right_val,
    input  logic          cmp_left,
    input  logic          cmp_right,
    output logic          vld,
    output logic [KW-1:0] key,
    output logic [VW-1:0] val,
    output logic          cmp
);

    pq_sel_e sel;

    // An empty cell always loses to the new entry, which keeps the compare
    // vector monotonic along the array.
    assign cmp = !vld || better(PQ_MAX_KW'(new_key), PQ_MAX_KW'(key), MIN_FIRST != 0);

    // On replace the array shifts toward cell 0 until the new entry's slot; the
    // old head's compare is meaningless since that entry is being discarded.
    always_comb begin
        sel = SEL_HOLD;
        case (op)
            OP_INSERT: begin
                if (cmp_left) begin
                    sel = SEL_LEFT;
                end else if (cmp) begin
                    sel = SEL_NEW;
                end
            end
            OP_REMOVE: sel = SEL_RIGHT;
            OP_REPLACE: begin
                if (cmp && !FIRST) begin
                    sel = SEL_HOLD;
                end else if (cmp_right) begin
                    sel = SEL_NEW;
                end else begin
                    sel = SEL_RIGHT;
                end
            end
            default: sel = SEL_HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= 1'b0;
            key <= '0;
            val <= '0;
        end else begin
            case (sel)
                SEL_LEFT: begin
                    vld <= left_vld;
                    key <= left_key;
                    val <= left_val;
                end
                SEL_RIGHT: begin
                    vld <= right_vld;
                    key <= right_key;
                    val <= right_val;
                end
                SEL_NEW: begin
                    vld <= 1'b1;
                    key <= new_key;
                    val <= new_val;
                end
                default: begin
                    vld <= vld;
                    key <= key;
                    val <= val;
                end
            endcase
        end
    end

endmodule

// File: rtl/pq_shift_array.sv
// Single-cycle sorted priority queue built from DEPTH pq_cell instances; evicts
// the lowest-priority entry on overflow instead of stalling.
module pq_shift_array
    import pq_pkg::*;
#(
    parameter int KW        = 8,
    parameter int VW        = 8,
    parameter int DEPTH     = 8,
    parameter int MIN_FIRST = 1,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enq,
    input  logic          deq,
    input  logic          repl,
    input  logic [KW-1:0] key_i,
    input  logic [VW-1:0] val_i,
    output logic          rdy_o,
    output logic          top_vld_o,
    output logic [KW-1:0] top_key_o,
    output logic [VW-1:0] top_val_o,
    output logic          evict_vld_o,
    output logic [KW-1:0] evict_key_o,
    output logic [VW-1:0] evict_val_o,
    output logic [CW-1:0] cnt_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [DEPTH-1:0] cell_vld;
    logic [DEPTH-1:0] cell_cmp;
    logic [KW-1:0]    cell_key [DEPTH];
    logic [VW-1:0]    cell_val [DEPTH];
    pq_op_e           op;

    assign full_o  = (cnt_o == CW'(DEPTH));
    assign empty_o = (cnt_o == '0);

    // Replace on an empty queue has nothing to discard, so it is a plain insert.
    always_comb begin
        op = OP_NOP;
        if (rdy_o) begin
            op = decode_op(enq, deq, repl);
            if (op == OP_REPLACE && empty_o) begin
                op = OP_INSERT;
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        logic          l_vld, r_vld, l_cmp, r_cmp;
        logic [KW-1:0] l_key, r_key;
        logic [VW-1:0] l_val, r_val;

        if (i == 0) begin : g_head
            assign l_vld = 1'b0;
            assign l_key = '0;
            assign l_val = '0;
            assign l_cmp = 1'b0;
        end else begin : g_body
            assign l_vld = cell_vld[i-1];
            assign l_key = cell_key[i-1];
            assign l_val = cell_val[i-1];
            assign l_cmp = cell_cmp[i-1];
        end

        if (i == DEPTH - 1) begin : g_tail
            assign r_vld = 1'b0;
            assign r_key = '0;
            assign r_val = '0;
            assign r_cmp = 1'b1;
        end else begin : g_inner
            assign r_vld = cell_vld[i+1];
            assign r_key = cell_key[i+1];
            assign r_val = cell_val[i+1];
            assign r_cmp = cell_cmp[i+1];
        end

        pq_cell #(
            .KW(KW), .VW(VW), .MIN_FIRST(MIN_FIRST), .FIRST(i == 0)
        ) u_cell (
            .clk(clk), .rst(rst), .op(op),
            .new_key(key_i), .new_val(val_i),
            .left_vld(l_vld), .left_key(l_key), .left_val(l_val),
            .right_vld(r_vld), .right_key(r_key), .right_val(r_val),
            .cmp_left(l_cmp), .cmp_right(r_cmp),
            .vld(cell_vld[i]), .key(cell_key[i]), .val(cell_val[i]),
            .cmp(cell_cmp[i])
        );
    end

    assign top_vld_o = cell_vld[0];
    assign top_key_o = cell_key[0];
    assign top_val_o = cell_val[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_o <= 1'b0;
            cnt_o <= '0;
        end else begin
            rdy_o <= 1'b1;
            if (op == OP_INSERT && !full_o) begin
                cnt_o <= cnt_o + CW'(1);
            end else if (op == OP_REMOVE && !empty_o) begin
                cnt_o <= cnt_o - CW'(1);
            end
        end
    end

    // When full, whichever of the tail entry or the new entry ranks last is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evict_vld_o <= 1'b0;
            evict_key_o <= '0;
            evict_val_o <= '0;
        end else if (op == OP_INSERT && full_o) begin
            evict_vld_o <= 1'b1;
            evict_key_o <= cell_cmp[DEPTH-1] ? cell_key[DEPTH-1] : key_i;
            evict_val_o <= cell_cmp[DEPTH-1] ? cell_val[DEPTH-1] : val_i;
        end else begin
            evict_vld_o <= 1'b0;
            evict_key_o <= '0;
            evict_val_o <= '0;
        end
    end

endmodule

// File: tb/tb_pq_shift_array.sv
// Directed bench for pq_shift_array: three instances (depth 8 min-first,
// depth 4 min-first, depth 8 max-first) driven from one vector table.
module tb_pq_shift_array;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] enq = '0;
    logic [2:0] deq = '0;
    logic [2:0] repl = '0;
    logic [7:0] key_in [3];
    logic [7:0] val_in [3];

    logic       rdy [3];
    logic       tvld [3];
    logic [7:0] tkey [3];
    logic [7:0] tval [3];
    logic       evld [3];
    logic [7:0] ekey [3];
    logic [7:0] eval [3];
    logic       full [3];
    logic       empty [3];
    logic [3:0] cnt_a;
    logic [2:0] cnt_b;
    logic [3:0] cnt_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pq_shift_array #(.KW(8), .VW(8), .DEPTH(8), .MIN_FIRST(1)) u_dut_a (
        .clk(clk), .rst(rst), .enq(enq[0]), .deq(deq[0]), .repl(repl[0]),
        .key_i(key_in[0]), .val_i(val_in[0]), .rdy_o(rdy[0]),
        .top_vld_o(tvld[0]), .top_key_o(tkey[0]), .top_val_o(tval[0]),
        .evict_vld_o(evld[0]), .evict_key_o(ekey[0]), .evict_val_o(eval[0]),
        .cnt_o(cnt_a), .full_o(full[0]), .empty_o(empty[0])
    );

    pq_shift_array #(.KW(8), .VW(8), .DEPTH(4), .MIN_FIRST(1)) u_dut_b (
        .clk(clk), .rst(rst), .enq(enq[1]), .deq(deq[1]), .repl(repl[1]),
        .key_i(key_in[1]), .val_i(val_in[1]), .rdy_o(rdy[1]),
        .top_vld_o(tvld[1]), .top_key_o(tkey[1]), .top_val_o(tval[1]),
        .evict_vld_o(evld[1]), .evict_key_o(ekey[1]), .evict_val_o(eval[1]),
        .cnt_o(cnt_b), .full_o(full[1]), .empty_o(empty[1])
    );

    pq_shift_array #(.KW(8), .VW(8), .DEPTH(8), .MIN_FIRST(0)) u_dut_c (
        .clk(clk), .rst(rst), .enq(enq[2]), .deq(deq[2]), .repl(repl[2]),
        .key_i(key_in[2]), .val_i(val_in[2]), .rdy_o(rdy[2]),
        .top_vld_o(tvld[2]), .top_key_o(tkey[2]), .top_val_o(tval[2]),
        .evict_vld_o(evld[2]), .evict_key_o(ekey[2]), .evict_val_o(eval[2]),
        .cnt_o(cnt_c), .full_o(full[2]), .empty_o(empty[2])
    );

    typedef struct {
        int   dut;
        logic e, d, r;
        int   key, val;
        logic exp_tvld;
        int   exp_tkey, exp_tval, exp_cnt;
        logic exp_evld;
        int   exp_ekey, exp_eval;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int dut, input logic e, input logic d, input logic r,
                                input int key, input int val, input logic tv, input int tk,
                                input int tvl, input int c, input logic ev, input int ek,
                                input int evl);
        vec_t v;
        v.dut = dut; v.e = e; v.d = d; v.r = r; v.key = key; v.val = val;
        v.exp_tvld = tv; v.exp_tkey = tk; v.exp_tval = tvl; v.exp_cnt = c;
        v.exp_evld = ev; v.exp_ekey = ek; v.exp_eval = evl;
        return v;
    endfunction

    function automatic logic [31:0] get_cnt(input int dut);
        case (dut)
            0:       return 32'(cnt_a);
            1:       return 32'(cnt_b);
            default: return 32'(cnt_c);
        endcase
    endfunction

    function automatic int depth_of(input int dut);
        return (dut == 1) ? 4 : 8;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        enq[v.dut]    = v.e;
        deq[v.dut]    = v.d;
        repl[v.dut]   = v.r;
        key_in[v.dut] = 8'(v.key);
        val_in[v.dut] = 8'(v.val);
        @(posedge clk);
        #1;
        enq  = '0;
        deq  = '0;
        repl = '0;
    endtask

    task automatic check_output(input int idx, input vec_t v);
        string p;
        p = $sformatf("v%0d.u%0d", idx, v.dut);
        check({p, ".top_vld"}, 32'(tvld[v.dut]), 32'(v.exp_tvld));
        check({p, ".top_key"}, 32'(tkey[v.dut]), 32'(v.exp_tkey));
        check({p, ".top_val"}, 32'(tval[v.dut]), 32'(v.exp_tval));
        check({p, ".cnt"}, get_cnt(v.dut), 32'(v.exp_cnt));
        check({p, ".full"}, 32'(full[v.dut]), 32'(v.exp_cnt == depth_of(v.dut)));
        check({p, ".empty"}, 32'(empty[v.dut]), 32'(v.exp_cnt == 0));
        check({p, ".evict_vld"}, 32'(evld[v.dut]), 32'(v.exp_evld));
        if (v.exp_evld) begin
            check({p, ".evict_key"}, 32'(ekey[v.dut]), 32'(v.exp_ekey));
            check({p, ".evict_val"}, 32'(eval[v.dut]), 32'(v.exp_eval));
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            key_in[i] = '0;
            val_in[i] = '0;
        end

        // Instance 0: ordered inserts, drain, empty remove, FIFO ties, replace.
        vecs.push_back(mk(0, 1, 0, 0,  5, 1, 1,  5, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 10, 2, 1,  5, 1, 2, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,  3, 3, 1,  3, 3, 3, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 20, 4, 1,  3, 3, 4, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,  2, 5, 1,  2, 5, 5, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0, 0, 1,  3, 3, 4, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0, 0, 1,  5, 1, 3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0, 0, 1, 10, 2, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0, 0, 1, 20, 4, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,  7, 1, 1,  7, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,  7, 2, 1,  7, 1, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0, 0, 1,  7, 2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,  3, 1, 1,  3, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,  5, 2, 1,  3, 1, 2, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 10, 3, 1,  3, 1, 3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  4, 4, 1,  4, 4, 3, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 30, 5, 1,  5, 2, 3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0, 0, 1, 10, 3, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0, 0, 1, 30, 5, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  6, 6, 1,  6, 6, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1,  1, 7, 1,  1, 7, 1, 0, 0, 0));
        // Instance 1: overflow eviction of the new entry, of the tail, and of a tie.
        vecs.push_back(mk(1, 1, 0, 0,  1, 1, 1,  1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0,  2, 2, 1,  1, 1, 2, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0,  3, 3, 1,  1, 1, 3, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0,  4, 4, 1,  1, 1, 4, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0,  9, 9, 1,  1, 1, 4, 1, 9, 9));
        vecs.push_back(mk(1, 1, 0, 0,  0,10, 1,  0,10, 4, 1, 4, 4));
        vecs.push_back(mk(1, 0, 1, 0,  0, 0, 1,  1, 1, 3, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0,  3,11, 1,  1, 1, 4, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0,  3,12, 1,  1, 1, 4, 1, 3,12));
        vecs.push_back(mk(1, 0, 0, 1,  5,13, 1,  2, 2, 4, 0, 0, 0));
        // Instance 2: max-first ordering.
        vecs.push_back(mk(2, 1, 0, 0,  5, 1, 1,  5, 1, 1, 0, 0, 0));
        vecs.push_back(mk(2, 1, 0, 0, 27, 2, 1, 27, 2, 2, 0, 0, 0));
        vecs.push_back(mk(2, 1, 0, 0,  8, 3, 1, 27, 2, 3, 0, 0, 0));

        // Reset held for two cycles, then a request raced against the first ready edge.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst.rdy", 32'(rdy[0]), 32'd0);
        check("rst.cnt", get_cnt(0), 32'd0);
        check("rst.empty", 32'(empty[0]), 32'd1);
        check("rst.full", 32'(full[0]), 32'd0);
        check("rst.top_vld", 32'(tvld[0]), 32'd0);
        check("rst.evict_vld", 32'(evld[0]), 32'd0);
        rst       = 1'b1;
        enq[0]    = 1'b1;
        key_in[0] = 8'd42;
        val_in[0] = 8'd42;
        @(posedge clk);
        #1;
        enq = '0;
        check("rel.rdy", 32'(rdy[0]), 32'd1);
        check("rel.cnt_ignored", get_cnt(0), 32'd0);
        check("rel.top_vld_ignored", 32'(tvld[0]), 32'd0);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            check_output(i, vecs[i]);
        end

        // Asynchronous reset between clock edges empties every instance at once.
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst.top_vld_c", 32'(tvld[2]), 32'd0);
        check("arst.top_key_c", 32'(tkey[2]), 32'd0);
        check("arst.cnt_c", get_cnt(2), 32'd0);
        check("arst.rdy_c", 32'(rdy[2]), 32'd0);
        check("arst.cnt_b", get_cnt(1), 32'd0);
        check("arst.empty_b", 32'(empty[1]), 32'd1);
        check("arst.full_b", 32'(full[1]), 32'd0);
        check("arst.top_vld_a", 32'(tvld[0]), 32'd0);

        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
